kyber_encrypt_seq: RTL and testbench

Sequential Baby-Kyber encryptor (n=4, k=2, q=17). It is the transmit-side counterpart of the decryptor. It latches a public key (A, t), randomness r, errors e1/e2 and a 4-bit message on a start handshake. It then computes u = Aᵀ·r + e1 and v = tᵀ·r + e2 + encode(msg) in Z_q[x]/(x⁴+1) using one shared multiply-accumulate unit. The result is presented in the ciphertext layout the decryptor consumes.

---
 rtl/kyber_encrypt_seq.sv | 169 ++++++++++++++++
 tb/tb_kyber_encrypt_seq.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kyber_encrypt_seq.sv
// Sequential Baby-Kyber encryptor (n=4, k=2, q=17): u = A^T r + e1, v = t^T r + e2 + encode(msg),
// computed one output coefficient at a time on a single shared multiply-accumulate unit.
module kyber_encrypt_seq #(
  parameter int Q         = 17,
  parameter int N         = 4,
  parameter int K         = 2,
  parameter int W         = 32,
  parameter int MSG_SCALE = 9
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [K-1:0][K-1:0][N-1:0][W-1:0]     pk_a,
  input  logic [K-1:0][N-1:0][W-1:0]            pk_t,
  input  logic [K-1:0][N-1:0][W-1:0]            rand_r,
  input  logic [K-1:0][N-1:0][W-1:0]            err_e1,
  input  logic [N-1:0][W-1:0]                   err_e2,
  input  logic [3:0]                            msg,
  output logic                                  busy,
  output logic                                  done,
  output logic [1:0][1:0][N-1:0][W-1:0]         ciphertext
);

  localparam logic signed [W-1:0] QS   = W'(Q);
  localparam logic signed [W-1:0] MSGS = W'(MSG_SCALE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    FIN  = 2'd2
  } state_e;

  state_e                              state_q;
  logic [3:0]                          c_q;
  logic [2:0]                          s_q;
  logic signed [W-1:0]                 acc_q;
  logic [K-1:0][K-1:0][N-1:0][W-1:0]   a_q;
  logic [K-1:0][N-1:0][W-1:0]          t_q;
  logic [K-1:0][N-1:0][W-1:0]          r_q;
  logic [K-1:0][N-1:0][W-1:0]          e1_q;
  logic [N-1:0][W-1:0]                 e2_q;
  logic [3:0]                          msg_q;
  logic                                busy_q;
  logic                                done_q;
  logic [1:0][1:0][N-1:0][W-1:0]       ct_q;

  // Coefficient c selects output j (u0, u1, v) and coefficient k; step s selects row i and term l.
  logic [1:0]          j_s;
  logic [1:0]          k_s;
  logic                i_s;
  logic [1:0]          l_s;
  logic [1:0]          m_s;
  logic signed [W-1:0] opa_s;
  logic signed [W-1:0] prod_s;
  logic signed [W-1:0] base_s;
  logic signed [W-1:0] acc_d;
  logic signed [W-1:0] add_s;
  logic signed [W-1:0] sum_s;
  logic signed [W-1:0] rem_s;
  logic signed [W-1:0] res_d;

  assign j_s = c_q[3:2];
  assign k_s = c_q[1:0];
  assign i_s = s_q[2];
  assign l_s = s_q[1:0];
  assign m_s = k_s - l_s;

  // Multiply-accumulate datapath; terms with l > k wrap around x^4 = -1 and are subtracted.
  always_comb begin
    opa_s = '0;
    if (j_s == 2'd2) begin
      opa_s = $signed(t_q[i_s][l_s]);
    end else begin
      opa_s = $signed(a_q[i_s][j_s[0]][l_s]);
    end
    prod_s = opa_s * $signed(r_q[i_s][m_s]);
    base_s = (s_q == 3'd0) ? '0 : acc_q;
    if (l_s > k_s) begin
      acc_d = base_s - prod_s;
    end else begin
      acc_d = base_s + prod_s;
    end
  end

  // Finishing step: error/message term, then non-negative residue mod Q.
  always_comb begin
    add_s = '0;
    if (j_s == 2'd2) begin
      add_s = $signed(e2_q[k_s]) + (msg_q[2'd3 - k_s] ? MSGS : '0);
    end else begin
      add_s = $signed(e1_q[j_s[0]][k_s]);
    end
    sum_s = acc_q + add_s;
    rem_s = sum_s % QS;
    if (rem_s < 0) begin
      res_d = rem_s + QS;
    end else begin
      res_d = rem_s;
    end
  end

  // Control FSM, operand latches and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= 4'd0;
      s_q     <= 3'd0;
      acc_q   <= '0;
      a_q     <= '0;
      t_q     <= '0;
      r_q     <= '0;
      e1_q    <= '0;
      e2_q    <= '0;
      msg_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ct_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= pk_a;
            t_q     <= pk_t;
            r_q     <= rand_r;
            e1_q    <= err_e1;
            e2_q    <= err_e2;
            msg_q   <= msg;
            c_q     <= 4'd0;
            s_q     <= 3'd0;
            busy_q  <= 1'b1;
            state_q <= MAC;
          end else begin
            state_q <= IDLE;
          end
        end
        MAC: begin
          acc_q <= acc_d;
          s_q   <= s_q + 3'd1;
          if (s_q == 3'd7) begin
            state_q <= FIN;
          end else begin
            state_q <= MAC;
          end
        end
        FIN: begin
          ct_q[j_s[1]][j_s[0]][k_s] <= res_d;
          c_q <= c_q + 4'd1;
          s_q <= 3'd0;
          if (c_q == 4'd11) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            state_q <= MAC;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign ciphertext = ct_q;

endmodule

// File: tb/tb_kyber_encrypt_seq.sv
// Directed self-checking bench for kyber_encrypt_seq with hand-computed ciphertexts
// and a bench-side decryptor for the message round trip.
module tb_kyber_encrypt_seq;

  logic                            clk;
  logic                            rst_n;
  logic                            start;
  logic [1:0][1:0][3:0][31:0]      pk_a;
  logic [1:0][3:0][31:0]           pk_t;
  logic [1:0][3:0][31:0]           rand_r;
  logic [1:0][3:0][31:0]           err_e1;
  logic [3:0][31:0]                err_e2;
  logic [3:0]                      msg;
  logic                            busy;
  logic                            done;
  logic [1:0][1:0][3:0][31:0]      ciphertext;

  int checks;
  int failures;

  kyber_encrypt_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pk_a       (pk_a),
    .pk_t       (pk_t),
    .rand_r     (rand_r),
    .err_e1     (err_e1),
    .err_e2     (err_e2),
    .msg        (msg),
    .busy       (busy),
    .done       (done),
    .ciphertext (ciphertext)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    pk_a   = '0;
    pk_t   = '0;
    rand_r = '0;
    err_e1 = '0;
    err_e2 = '0;
    msg    = 4'd0;
  endtask

  task automatic set_wrap_inputs();
    clear_inputs();
    pk_a[0][0][1] = 32'd1;
    rand_r[0][3]  = 32'd1;
  endtask

  task automatic set_reduce_inputs();
    clear_inputs();
    for (int x = 0; x < 4; x++) pk_t[0][x] = 32'd16;
    rand_r[0][0] = 32'd1;
    err_e1[0][0] = 32'd3;
    err_e1[0][1] = -32'sd3;
    err_e2[0]    = 32'd1;
    err_e2[3]    = -32'sd17;
  endtask

  task automatic launch();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after the accepting edge until done, capped at 200.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) break;
    end
  endtask

  task automatic test_reset();
    int exp [16];
    clear_inputs();
    start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags busy=%b done=%b required busy=0 done=0", busy, done);
    end
    exp = '{16{0}};
    for (int x = 0; x < 16; x++) begin
      checks++;
      if (ciphertext[x/8][(x/4)%2][x%4] !== 32'(exp[x])) begin
        failures++;
        $display("FAIL reset_ct[%0d] got=%0d required=%0d", x, ciphertext[x/8][(x/4)%2][x%4], exp[x]);
      end
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero_msg();
    int exp [16];
    int cyc;
    int busy_low;
    clear_inputs();
    msg = 4'b1010;
    launch();
    msg = 4'b0101;
    cyc = 0;
    busy_low = 0;
    while (cyc < 200) begin
      if (!busy) busy_low++;
      @(posedge clk);
      #1;
      cyc++;
      if (done) break;
    end
    checks++;
    if (cyc !== 108) begin
      failures++;
      $display("FAIL zero_latency got=%0d required=108", cyc);
    end
    checks++;
    if (busy_low !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_busy low_cycles=%0d busy_at_done=%b required 0 and 0", busy_low, busy);
    end
    exp = '{0,0,0,0, 0,0,0,0, 9,0,9,0, 0,0,0,0};
    for (int x = 0; x < 16; x++) begin
      checks++;
      if (ciphertext[x/8][(x/4)%2][x%4] !== 32'(exp[x])) begin
        failures++;
        $display("FAIL zero_ct[%0d] got=%0d required=%0d", x, ciphertext[x/8][(x/4)%2][x%4], exp[x]);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL zero_done_pulse got=%b required=0", done);
    end
  endtask

  task automatic test_negacyclic();
    int exp [16];
    int cyc;
    set_wrap_inputs();
    launch();
    wait_done(cyc);
    checks++;
    if (cyc !== 108) begin
      failures++;
      $display("FAIL wrap_latency got=%0d required=108", cyc);
    end
    exp = '{16,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
    for (int x = 0; x < 16; x++) begin
      checks++;
      if (ciphertext[x/8][(x/4)%2][x%4] !== 32'(exp[x])) begin
        failures++;
        $display("FAIL wrap_ct[%0d] got=%0d required=%0d", x, ciphertext[x/8][(x/4)%2][x%4], exp[x]);
      end
    end
  endtask

  task automatic test_reduction();
    int exp [16];
    int cyc;
    set_reduce_inputs();
    launch();
    wait_done(cyc);
    checks++;
    if (cyc !== 108) begin
      failures++;
      $display("FAIL reduce_latency got=%0d required=108", cyc);
    end
    exp = '{3,14,0,0, 0,0,0,0, 0,16,16,16, 0,0,0,0};
    for (int x = 0; x < 16; x++) begin
      checks++;
      if (ciphertext[x/8][(x/4)%2][x%4] !== 32'(exp[x])) begin
        failures++;
        $display("FAIL reduce_ct[%0d] got=%0d required=%0d", x, ciphertext[x/8][(x/4)%2][x%4], exp[x]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int exp [16];
    int cyc;
    int ndone;
    set_wrap_inputs();
    launch();
    repeat (50) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || ciphertext !== '0) begin
      failures++;
      $display("FAIL midreset_clear busy=%b done=%b ct_u0_0=%0d required all 0", busy, done, ciphertext[0][0][0]);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ndone = 0;
    for (int n = 0; n < 120; n++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      failures++;
      $display("FAIL midreset_no_done got=%0d pulses required=0", ndone);
    end
    launch();
    wait_done(cyc);
    checks++;
    if (cyc !== 108) begin
      failures++;
      $display("FAIL midreset_latency got=%0d required=108", cyc);
    end
    exp = '{16,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
    for (int x = 0; x < 16; x++) begin
      checks++;
      if (ciphertext[x/8][(x/4)%2][x%4] !== 32'(exp[x])) begin
        failures++;
        $display("FAIL midreset_ct[%0d] got=%0d required=%0d", x, ciphertext[x/8][(x/4)%2][x%4], exp[x]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int exp [16];
    int cyc;
    int ndone;
    int done_cyc;
    set_reduce_inputs();
    launch();
    set_wrap_inputs();
    msg = 4'hF;
    ndone = 0;
    done_cyc = 0;
    for (cyc = 1; cyc <= 130; cyc++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        done_cyc = cyc;
      end
      start = (cyc == 10 || cyc == 60);
    end
    start = 1'b0;
    checks++;
    if (ndone !== 1 || done_cyc !== 108) begin
      failures++;
      $display("FAIL busy_start_done count=%0d at=%0d required 1 at 108", ndone, done_cyc);
    end
    exp = '{3,14,0,0, 0,0,0,0, 0,16,16,16, 0,0,0,0};
    for (int x = 0; x < 16; x++) begin
      checks++;
      if (ciphertext[x/8][(x/4)%2][x%4] !== 32'(exp[x])) begin
        failures++;
        $display("FAIL busy_start_ct[%0d] got=%0d required=%0d", x, ciphertext[x/8][(x/4)%2][x%4], exp[x]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int exp [16];
    int cyc;
    set_wrap_inputs();
    launch();
    wait_done(cyc);
    checks++;
    if (cyc !== 108 || ciphertext[0][0][0] !== 32'd16) begin
      failures++;
      $display("FAIL b2b_first latency=%0d u0_0=%0d required 108 and 16", cyc, ciphertext[0][0][0]);
    end
    clear_inputs();
    msg = 4'b1010;
    launch();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept busy=%b done=%b required busy=1 done=0", busy, done);
    end
    wait_done(cyc);
    checks++;
    if (cyc !== 108) begin
      failures++;
      $display("FAIL b2b_latency got=%0d required=108", cyc);
    end
    exp = '{0,0,0,0, 0,0,0,0, 9,0,9,0, 0,0,0,0};
    for (int x = 0; x < 16; x++) begin
      checks++;
      if (ciphertext[x/8][(x/4)%2][x%4] !== 32'(exp[x])) begin
        failures++;
        $display("FAIL b2b_ct[%0d] got=%0d required=%0d", x, ciphertext[x/8][(x/4)%2][x%4], exp[x]);
      end
    end
  endtask

  // Secret s = (1, 0), e = ([1,0,0,0], 0): t = A*s + e, and decryption reduces to v - u0.
  task automatic test_round_trip();
    int cyc;
    int d;
    logic [3:0] dec;
    for (int m = 0; m < 16; m++) begin
      clear_inputs();
      pk_a[0][0] = {32'd11, 32'd7, 32'd5, 32'd3};
      pk_a[0][1] = {32'd6, 32'd4, 32'd13, 32'd2};
      pk_a[1][0] = {32'd9, 32'd15, 32'd1, 32'd8};
      pk_a[1][1] = {32'd14, 32'd0, 32'd12, 32'd10};
      pk_t[0]    = {32'd11, 32'd7, 32'd5, 32'd4};
      pk_t[1]    = {32'd9, 32'd15, 32'd1, 32'd8};
      rand_r[0][0] = 32'd1;
      rand_r[1][1] = 32'd1;
      err_e1[0][0] = 32'd1;
      err_e1[0][2] = -32'sd1;
      err_e1[1][1] = -32'sd1;
      err_e1[1][3] = 32'd1;
      err_e2[1]    = 32'd1;
      err_e2[3]    = -32'sd1;
      msg = 4'(m);
      launch();
      wait_done(cyc);
      dec = 4'd0;
      for (int k = 0; k < 4; k++) begin
        d = (int'($signed(ciphertext[1][0][k])) - int'($signed(ciphertext[0][0][k]))) % 17;
        if (d < 0) d = d + 17;
        dec[3-k] = (d >= 5 && d <= 12);
      end
      checks++;
      if (cyc !== 108 || dec !== 4'(m)) begin
        failures++;
        $display("FAIL round_trip msg=%0d decoded=%0d latency=%0d required decoded=%0d latency=108", m, dec, cyc, m);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    start    = 1'b0;
    rst_n    = 1'b1;
    clear_inputs();
    #2;
    test_reset();
    test_zero_msg();
    test_negacyclic();
    test_reduction();
    test_reset_mid();
    test_start_while_busy();
    test_back_to_back();
    test_round_trip();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
